// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder and the control unit:
// mnemonic codes, 8-bit opcode constants, encoded-word field positions
// and the packed layout of an encoded word.
package instr_encoder_pkg;

    // Mnemonic codes presented on IN_OP; 12..15 are illegal.
    typedef enum logic [3:0] {
        MN_LOADI = 4'd0,
        MN_MOV   = 4'd1,
        MN_ADD   = 4'd2,
        MN_SUB   = 4'd3,
        MN_AND   = 4'd4,
        MN_OR    = 4'd5,
        MN_J     = 4'd6,
        MN_BEQ   = 4'd7,
        MN_BNE   = 4'd8,
        MN_SLL   = 4'd9,
        MN_SRL   = 4'd10,
        MN_SRA   = 4'd11
    } mnemonic_e;

    // Opcode byte placed in bits [31:24] of the encoded word.
    localparam logic [7:0] OPC_LOADI = 8'h00;
    localparam logic [7:0] OPC_MOV   = 8'h01;
    localparam logic [7:0] OPC_ADD   = 8'h02;
    localparam logic [7:0] OPC_SUB   = 8'h03;
    localparam logic [7:0] OPC_AND   = 8'h04;
    localparam logic [7:0] OPC_OR    = 8'h05;
    localparam logic [7:0] OPC_J     = 8'h06;
    localparam logic [7:0] OPC_BEQ   = 8'h07;
    localparam logic [7:0] OPC_BNE   = 8'h0A;
    localparam logic [7:0] OPC_SLL   = 8'h0B;
    localparam logic [7:0] OPC_SRL   = 8'h0C;
    localparam logic [7:0] OPC_SRA   = 8'h0D;

    // Field bit positions within the 32-bit encoded word.
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 24;
    localparam int unsigned DST_MSB  = 23;
    localparam int unsigned DST_LSB  = 16;
    localparam int unsigned SRC1_MSB = 15;
    localparam int unsigned SRC1_LSB = 8;
    localparam int unsigned SRC2_MSB = 7;
    localparam int unsigned SRC2_LSB = 0;

    // Encoded word layout, MSB first.
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_word_t;

    // Register numbers are zero-extended into 8-bit fields.
    function automatic logic [7:0] zext_reg(input logic [2:0] r);
        return {5'b0, r};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Encoded-word buffer: DEPTH-entry circular FIFO of 32-bit words.
// Ports: CLK, RESET (sync, active-high), push_i/wdata_i write the tail,
// pop_i advances the head, rdata_c is the head entry (valid when
// level_o != 0), level_o is the registered occupancy.
module instr_fifo
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [INSTR_W-1:0]         wdata_i,
    output logic [INSTR_W-1:0]         rdata_c,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               do_push, do_pop;

    // Guard against overflow/underflow even if the caller does not.
    assign do_push = push_i && (level_q < LW'(DEPTH));
    assign do_pop  = pop_i && (level_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is only observed when level != 0.
    always_ff @(posedge CLK) begin
        if (do_push && !RESET) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_c = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: turns a mnemonic request into a 32-bit word
// {opcode, dest, src1, src2/imm} and buffers it for the consumer.
// Ports: CLK, RESET (sync, active-high); request side IN_VALID/IN_READY
// with IN_OP, IN_RD, IN_RS1, IN_RS2, IN_IMM; word side OUT_VALID/OUT_READY
// with INSTRUCTION; ILLEGAL pulses one cycle after an illegal request is
// accepted; LEVEL is the buffer occupancy.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [3:0]             IN_OP,
    input  logic [2:0]             IN_RD,
    input  logic [2:0]             IN_RS1,
    input  logic [2:0]             IN_RS2,
    input  logic [7:0]             IN_IMM,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [31:0]            INSTRUCTION,
    output logic                   ILLEGAL,
    output logic [$clog2(DEPTH):0] LEVEL
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    instr_word_t     enc_c;
    logic            legal_c;
    logic            in_fire, push, pop;
    logic [31:0]     head_c;
    logic [LW-1:0]   level;
    logic            illegal_q, illegal_d;

    // Combinational encoding of the presented request.
    always_comb begin
        enc_c   = '0;
        legal_c = 1'b1;
        case (mnemonic_e'(IN_OP))
            MN_LOADI: begin enc_c.opcode = OPC_LOADI; enc_c.dest = zext_reg(IN_RD);
                            enc_c.src2 = IN_IMM; end
            MN_MOV:   begin enc_c.opcode = OPC_MOV;   enc_c.dest = zext_reg(IN_RD);
                            enc_c.src2 = zext_reg(IN_RS2); end
            MN_ADD, MN_SUB, MN_AND, MN_OR: begin
                enc_c.opcode = (IN_OP == MN_ADD) ? OPC_ADD :
                               (IN_OP == MN_SUB) ? OPC_SUB :
                               (IN_OP == MN_AND) ? OPC_AND : OPC_OR;
                enc_c.dest = zext_reg(IN_RD);
                enc_c.src1 = zext_reg(IN_RS1);
                enc_c.src2 = zext_reg(IN_RS2);
            end
            MN_J:     begin enc_c.opcode = OPC_J; enc_c.dest = IN_IMM; end
            MN_BEQ, MN_BNE: begin
                enc_c.opcode = (IN_OP == MN_BEQ) ? OPC_BEQ : OPC_BNE;
                enc_c.dest = IN_IMM;
                enc_c.src1 = zext_reg(IN_RS1);
                enc_c.src2 = zext_reg(IN_RS2);
            end
            MN_SLL, MN_SRL, MN_SRA: begin
                enc_c.opcode = (IN_OP == MN_SLL) ? OPC_SLL :
                               (IN_OP == MN_SRL) ? OPC_SRL : OPC_SRA;
                enc_c.dest = zext_reg(IN_RD);
                enc_c.src1 = zext_reg(IN_RS1);
                enc_c.src2 = IN_IMM;
            end
            default: legal_c = 1'b0;
        endcase
    end

    // Handshakes depend only on registered occupancy.
    assign IN_READY  = (level < LW'(DEPTH));
    assign OUT_VALID = (level != '0);
    assign in_fire   = IN_VALID && IN_READY;
    assign push      = in_fire && legal_c;
    assign pop       = OUT_VALID && OUT_READY;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (enc_c),
        .rdata_c (head_c),
        .level_o (level)
    );

    // Illegal requests are consumed but flagged for one cycle.
    assign illegal_d = in_fire && !legal_c;

    always_ff @(posedge CLK) begin
        if (RESET) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end

    assign ILLEGAL     = illegal_q;
    assign INSTRUCTION = OUT_VALID ? head_c : 32'h0;
    assign LEVEL       = level;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [3:0]  IN_OP;
    logic [2:0]  IN_RD, IN_RS1, IN_RS2;
    logic [7:0]  IN_IMM;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] INSTRUCTION;
    logic        ILLEGAL;
    logic [2:0]  LEVEL;

    always #5 CLK = ~CLK;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP),
        .IN_RD(IN_RD), .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_IMM(IN_IMM),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .INSTRUCTION(INSTRUCTION), .ILLEGAL(ILLEGAL), .LEVEL(LEVEL)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mq[$];
    logic        exp_ill = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [7:0]  imm;
        logic [31:0] word;
        logic        legal;
    } vec_t;
    vec_t vecs[14];

    // Reference encoding: opcode table plus a per-mnemonic field recipe.
    function automatic logic [32:0] ref_enc(input logic [3:0] op, input logic [2:0] rd,
                                            input logic [2:0] rs1, input logic [2:0] rs2,
                                            input logic [7:0] imm);
        logic [7:0] opc [12];
        logic [7:0] d, s1, s2;
        opc = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h0A, 8'h0B, 8'h0C, 8'h0D};
        if (op > 4'd11) return 33'h0;
        d = 8'h00; s1 = 8'h00; s2 = 8'h00;
        if (op == 0)                 begin d = 8'(rd);  s2 = imm;         end
        else if (op == 1)            begin d = 8'(rd);  s2 = 8'(rs2);     end
        else if (op <= 5)            begin d = 8'(rd);  s1 = 8'(rs1); s2 = 8'(rs2); end
        else if (op == 6)            begin d = imm;                       end
        else if (op <= 8)            begin d = imm;     s1 = 8'(rs1); s2 = 8'(rs2); end
        else                         begin d = 8'(rd);  s1 = 8'(rs1); s2 = imm; end
        return {1'b1, opc[op], d, s1, s2};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_state();
        check("level", 32'(LEVEL), 32'(mq.size()));
        check("out_valid", 32'(OUT_VALID), 32'(mq.size() != 0));
        check("in_ready", 32'(IN_READY), 32'(mq.size() < DEPTH));
        check("instruction", INSTRUCTION, (mq.size() != 0) ? mq[0] : 32'h0);
        check("illegal", 32'(ILLEGAL), 32'(exp_ill));
    endtask

    // One clock: check current outputs, drive inputs, advance model at edge.
    task automatic cycle(input bit rst, input bit v, input logic [3:0] op,
                         input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [7:0] imm, input bit ordy);
        logic [32:0] e;
        bit do_pop, do_push;
        RESET = rst; IN_VALID = v; IN_OP = op; IN_RD = rd; IN_RS1 = rs1;
        IN_RS2 = rs2; IN_IMM = imm; OUT_READY = ordy;
        check_state();
        @(posedge CLK);
        e = ref_enc(op, rd, rs1, rs2, imm);
        if (rst) begin
            mq.delete();
            exp_ill = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && ordy;
            do_push = v && (mq.size() < DEPTH);
            exp_ill = do_push && !e[32];
            if (do_pop) void'(mq.pop_front());
            if (do_push && e[32]) mq.push_back(e[31:0]);
        end
        @(negedge CLK);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 8'd0, ordy);
    endtask

    task automatic push_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [7:0] imm, input bit ordy);
        cycle(1'b0, 1'b1, op, rd, rs1, rs2, imm, ordy);
    endtask

    initial begin
        RESET = 1'b1; IN_VALID = 1'b0; IN_OP = '0; IN_RD = '0; IN_RS1 = '0;
        IN_RS2 = '0; IN_IMM = '0; OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_level", 32'(LEVEL), 32'd0);
        check("reset_out_valid", 32'(OUT_VALID), 32'd0);
        check("reset_instruction", INSTRUCTION, 32'h0);
        check("reset_illegal", 32'(ILLEGAL), 32'd0);
        check("reset_in_ready", 32'(IN_READY), 32'd1);

        // Single-word vectors on an empty buffer.
        vecs[0]  = '{4'd2,  3'd4, 3'd2, 3'd1, 8'h00, 32'h02040201, 1'b1};
        vecs[1]  = '{4'd0,  3'd3, 3'd0, 3'd0, 8'h5A, 32'h0003005A, 1'b1};
        vecs[2]  = '{4'd7,  3'd0, 3'd1, 3'd2, 8'hFE, 32'h07FE0102, 1'b1};
        vecs[3]  = '{4'd11, 3'd5, 3'd6, 3'd0, 8'h02, 32'h0D050602, 1'b1};
        vecs[4]  = '{4'd1,  3'd7, 3'd3, 3'd5, 8'hAA, 32'h01070005, 1'b1};
        vecs[5]  = '{4'd6,  3'd7, 3'd7, 3'd7, 8'h80, 32'h06800000, 1'b1};
        vecs[6]  = '{4'd8,  3'd1, 3'd7, 3'd0, 8'h03, 32'h0A030700, 1'b1};
        vecs[7]  = '{4'd9,  3'd1, 3'd2, 3'd6, 8'h1F, 32'h0B01021F, 1'b1};
        vecs[8]  = '{4'd10, 3'd0, 3'd0, 3'd0, 8'hFF, 32'h0C0000FF, 1'b1};
        vecs[9]  = '{4'd5,  3'd6, 3'd5, 3'd4, 8'h11, 32'h05060504, 1'b1};
        vecs[10] = '{4'd3,  3'd1, 3'd2, 3'd3, 8'h00, 32'h03010203, 1'b1};
        vecs[11] = '{4'd4,  3'd2, 3'd3, 3'd4, 8'h00, 32'h04020304, 1'b1};
        vecs[12] = '{4'd12, 3'd1, 3'd1, 3'd1, 8'h01, 32'h00000000, 1'b0};
        vecs[13] = '{4'd15, 3'd7, 3'd7, 3'd7, 8'hFF, 32'h00000000, 1'b0};
        for (int i = 0; i < 14; i++) begin
            push_op(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b0);
            check("vec_word", INSTRUCTION, vecs[i].word);
            check("vec_out_valid", 32'(OUT_VALID), 32'(vecs[i].legal));
            check("vec_illegal", 32'(ILLEGAL), 32'(!vecs[i].legal));
            idle(1'b1);
        end
        idle(1'b0);

        // Three-word ordered sequence.
        push_op(4'd0, 3'd3, 3'd0, 3'd0, 8'h5A, 1'b0);
        push_op(4'd7, 3'd0, 3'd1, 3'd2, 8'hFE, 1'b0);
        push_op(4'd11, 3'd5, 3'd6, 3'd0, 8'h02, 1'b0);
        check("seq_w0", INSTRUCTION, 32'h0003005A);
        idle(1'b1);
        check("seq_w1", INSTRUCTION, 32'h07FE0102);
        idle(1'b1);
        check("seq_w2", INSTRUCTION, 32'h0D050602);
        idle(1'b1);
        check("seq_empty", 32'(OUT_VALID), 32'd0);

        // Fill with consumer stalled, then one pop frees a slot.
        for (int i = 0; i < 5; i++) push_op(4'd2, 3'(i), 3'd1, 3'd2, 8'h00, 1'b0);
        check("full_in_ready", 32'(IN_READY), 32'd0);
        check("full_level", 32'(LEVEL), 32'd4);
        check("full_head_stable", INSTRUCTION, 32'h02000102);
        push_op(4'd2, 3'd4, 3'd1, 3'd2, 8'h00, 1'b1);
        check("after_pop_in_ready", 32'(IN_READY), 32'd1);
        check("after_pop_level", 32'(LEVEL), 32'd3);
        push_op(4'd2, 3'd4, 3'd1, 3'd2, 8'h00, 1'b0);
        check("fifth_level", 32'(LEVEL), 32'd4);
        repeat (3) idle(1'b1);
        check("fifth_word", INSTRUCTION, 32'h02040102);
        idle(1'b1);

        // Illegal mnemonic is consumed without buffering.
        push_op(4'd1, 3'd2, 3'd0, 3'd3, 8'h00, 1'b0);
        push_op(4'd13, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0);
        check("ill_pulse", 32'(ILLEGAL), 32'd1);
        check("ill_level", 32'(LEVEL), 32'd1);
        idle(1'b0);
        check("ill_pulse_end", 32'(ILLEGAL), 32'd0);
        idle(1'b1);

        // Push and pop on the same edge at LEVEL=2.
        push_op(4'd1, 3'd1, 3'd0, 3'd1, 8'h00, 1'b0);
        push_op(4'd1, 3'd2, 3'd0, 3'd2, 8'h00, 1'b0);
        push_op(4'd1, 3'd3, 3'd0, 3'd3, 8'h00, 1'b1);
        check("pp_level", 32'(LEVEL), 32'd2);
        check("pp_head", INSTRUCTION, 32'h01020002);
        repeat (2) idle(1'b1);

        // Reset mid-operation, then traffic across pointer wrap.
        for (int i = 0; i < 3; i++) push_op(4'd0, 3'(i), 3'd0, 3'd0, 8'(i), 1'b0);
        cycle(1'b1, 1'b1, 4'd0, 3'd7, 3'd0, 3'd0, 8'h77, 1'b0);
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_instruction", INSTRUCTION, 32'h0);
        push_op(4'd0, 3'd1, 3'd0, 3'd0, 8'h10, 1'b0);
        for (int i = 0; i < 10; i++) push_op(4'd0, 3'(i), 3'd0, 3'd0, 8'(8'h20 + i), 1'b1);
        repeat (2) idle(1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                  4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
                  8'($urandom), ($urandom_range(0, 9) < 5));
        end
        repeat (DEPTH + 1) idle(1'b1);
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning encoded-word buffer entries (power of two, >=2).
REQ-002 The block SHALL have CLK  input  1  rising-edge clock.
REQ-003 The block SHALL have RESET  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have IN_VALID  input  1  request holds a valid instruction.
REQ-005 The block SHALL have IN_READY  output  1  block accepts a request this cycle.
REQ-006 The block SHALL have IN_OP  input  4  mnemonic code: 0 loadi, 1 mov, 2 add, 3 sub, 4 and, 5 or, 6 j, 7 beq, 8 bne, 9 sll, 10 srl, 11 sra, 12-15 illegal.
REQ-007 The block SHALL have IN_RD, IN_RS1, IN_RS2  input  3 each  destination, source-1 and source-2 register numbers.
REQ-008 The block SHALL have IN_IMM  input  8  immediate, branch/jump offset or shift amount.
REQ-009 The block SHALL have OUT_VALID  output  1  INSTRUCTION holds a valid word.
REQ-010 The block SHALL have OUT_READY  input  1  consumer takes the word this cycle.
REQ-011 The block SHALL have INSTRUCTION  output  32  encoded word: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm.
REQ-012 The block SHALL have ILLEGAL  output  1  one-cycle pulse on an illegal mnemonic.
REQ-013 The block SHALL have LEVEL  output  log2(DEPTH)+1  buffer occupancy.

Function
REQ-014 Opcode mapping SHALL be loadi 0x00, mov 0x01, add 0x02, sub 0x03, and 0x04, or 0x05, j 0x06, beq 0x07, bne 0x0A, sll 0x0B, srl 0x0C, sra 0x0D.
REQ-015 Register fields SHALL be zero-extended 3->8 bits; unused fields SHALL be 0x00.
REQ-016 Field use: loadi {rd,0,imm}; mov {rd,0,rs2}; add/sub/and/or {rd,rs1,rs2}; j {imm,0,0}; beq/bne {imm,rs1,rs2}; sll/srl/sra {rd,rs1,imm}.
REQ-017 A request SHALL be accepted on a rising edge where IN_VALID and IN_READY are both 1.
REQ-018 IN_READY SHALL equal (LEVEL < DEPTH), registered-state only, with no combinational dependence on OUT_READY.
REQ-019 An accepted legal request SHALL be written to the tail of the buffer at that edge.
REQ-020 An accepted illegal request SHALL NOT be buffered, and ILLEGAL SHALL be 1 for exactly the following cycle.
REQ-021 OUT_VALID SHALL equal (LEVEL != 0), and INSTRUCTION SHALL be the head entry when OUT_VALID=1 and 0x00000000 otherwise.
REQ-022 Latency: a word accepted at edge k SHALL appear on INSTRUCTION in the cycle after edge k when the buffer was empty.
REQ-023 A pop SHALL occur on an edge where OUT_VALID and OUT_READY are both 1, advancing the head by one.
REQ-024 INSTRUCTION SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 Simultaneous push and pop SHALL leave LEVEL unchanged and preserve order.
REQ-026 When full, pop-only SHALL be possible, and IN_READY SHALL rise in the cycle after the pop.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 Words SHALL leave the block in acceptance order, with no loss or duplication.

Reset
REQ-029 While RESET=1 at an edge, LEVEL=0, pointers=0, OUT_VALID=0, INSTRUCTION=0, ILLEGAL=0 and IN_READY=1 SHALL hold after that edge.
REQ-030 Reset mid-operation SHALL discard all buffered words, and no request SHALL be accepted on a reset edge.

Structure
REQ-031 A shared package SHALL hold the mnemonic codes, 8-bit opcode constants and field bit positions, for use by this block and the control unit.
REQ-032 Buffering SHALL be a sub-module instr_fifo (parameter DEPTH, 32-bit, push/pop/level), and encoding SHALL be combinational logic in instr_encoder.

Verification
REQ-033 Empty buffer; add rd=4 rs1=2 rs2=1 -> next cycle INSTRUCTION=0x02040201, OUT_VALID=1.
REQ-034 Sequence loadi rd=3 imm=0x5A, beq imm=0xFE rs1=1 rs2=2, sra rd=5 rs1=6 imm=2 -> 0x0003005A, 0x07FE0102, 0x0D050602, in order.
REQ-035 OUT_READY=0 with 5 pushes attempted -> 4 accepted, IN_READY=0, LEVEL=4; one pop -> IN_READY=1 next cycle and the 5th word is accepted afterwards.
REQ-036 IN_OP=13 -> IN_READY handshake completes, ILLEGAL=1 for one cycle, LEVEL unchanged.
REQ-037 LEVEL=2 with push and pop on the same edge -> LEVEL stays 2 and the head becomes word 2.
REQ-038 RESET asserted with LEVEL=3 -> next cycle LEVEL=0, OUT_VALID=0, INSTRUCTION=0; 10 push/pop cycles across pointer wrap -> order intact.
